// File: rtl/dram_write_buffer_pkg.sv
// Shared types, constants and helpers for the scratchpad DRAM write path.
//   dram_wbuf_entry_t  : one buffered write beat (addr, wdata, strb)
//   DRAM_BEAT_BYTES    : bytes per DRAM beat
//   LANES_PER_BEAT     : 16-bit scratchpad lanes per DRAM beat
//   lane_mask_to_strb  : row lane mask + beat index -> byte strobe
package dram_write_buffer_pkg;

  localparam int unsigned DRAM_BEAT_BYTES = 8;
  localparam int unsigned LANES_PER_BEAT  = 4;
  localparam int unsigned WBUF_ADDR_WIDTH = 32;
  // Widest row mask the strobe helper understands (8 beats x 4 lanes).
  localparam int unsigned WBUF_MASK_WIDTH = 32;

  typedef struct packed {
    logic [WBUF_ADDR_WIDTH-1:0] addr;
    logic [63:0]                wdata;
    logic [DRAM_BEAT_BYTES-1:0] strb;
  } dram_wbuf_entry_t;

  // Each 16-bit lane enables two adjacent byte strobes.
  function automatic logic [DRAM_BEAT_BYTES-1:0] lane_mask_to_strb(
    input logic [WBUF_MASK_WIDTH-1:0] mask,
    input logic [2:0]                 beat_idx
  );
    logic [DRAM_BEAT_BYTES-1:0] s;
    int unsigned idx;
    s = '0;
    for (int unsigned i = 0; i < LANES_PER_BEAT; i++) begin
      idx = LANES_PER_BEAT * int'(beat_idx) + i;
      s[2*i +: 2] = {2{mask[idx]}};
    end
    return s;
  endfunction

endpackage

// File: rtl/dram_write_buffer_if.sv
// Write-latch and DRAM-controller signals of dram_write_buffer.
//   slave  : the buffer's view (beat in, request out, acks in, status out)
//   master : the surrounding environment's view
interface dram_write_buffer_if #(
  parameter int unsigned DRAM_ADDR_WIDTH = 32,
  parameter int unsigned NUM_COLS        = 32,
  parameter int unsigned MAX_OUTSTANDING = 8
);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                       in_valid;
  logic [63:0]                in_wdata;
  logic [DRAM_ADDR_WIDTH-1:0] in_addr;
  logic [NUM_COLS-1:0]        in_mask;
  logic                       be_stall;
  logic                       dram_req_valid;
  logic                       dram_req_ready;
  logic [DRAM_ADDR_WIDTH-1:0] dram_req_addr;
  logic [63:0]                dram_req_wdata;
  logic [7:0]                 dram_req_strb;
  logic                       dram_resp_valid;
  logic [OUT_W-1:0]           outstanding;
  logic                       idle;
  logic                       err_resp;

  modport slave (
    input  in_valid, in_wdata, in_addr, in_mask, dram_req_ready, dram_resp_valid,
    output be_stall, dram_req_valid, dram_req_addr, dram_req_wdata, dram_req_strb,
           outstanding, idle, err_resp
  );

  modport master (
    output in_valid, in_wdata, in_addr, in_mask, dram_req_ready, dram_resp_valid,
    input  be_stall, dram_req_valid, dram_req_addr, dram_req_wdata, dram_req_strb,
           outstanding, idle, err_resp
  );
endinterface

// File: rtl/dram_write_buffer_sync_fifo.sv
// scpad_sync_fifo: generic synchronous FIFO.
//   clk, n_rst (async active-low), wr_en/wr_data, rd_en/rd_data,
//   full, empty, count. rd_data shows the head entry, 0 when empty.
//   Writes while full and reads while empty are ignored.
module scpad_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_do;
  logic             rd_do;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign wr_do = wr_en && !full;
  assign rd_do = rd_en && !empty;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_do) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_do) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_do, rd_do})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (wr_do) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dram_write_buffer.sv
// dram_write_buffer: buffers write beats from the scratchpad write latch,
// converts the row lane mask to a byte strobe, issues beats to the DRAM
// controller and tracks unacked writes.
//   clk, n_rst : clock, async active-low reset
//   bus        : dram_write_buffer_if.slave (latch beat in + be_stall,
//                DRAM request/ack channel, outstanding/idle/err_resp status)
module dram_write_buffer
  import dram_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned DRAM_ADDR_WIDTH = 32,
  parameter int unsigned NUM_COLS        = 32,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  dram_write_buffer_if.slave  bus
);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DRAM_ADDR_WIDTH-1:0] addr;
    logic [63:0]                wdata;
    logic [DRAM_BEAT_BYTES-1:0] strb;
  } entry_t;

  entry_t                     in_entry;
  entry_t                     head;
  logic [WBUF_MASK_WIDTH-1:0] mask_ext;
  logic                       accept;
  logic                       push;
  logic                       issue;
  logic                       req_valid;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CNT_W-1:0]           fifo_count;
  logic [OUT_W-1:0]           outstanding;
  logic                       err_resp;

  assign mask_ext = WBUF_MASK_WIDTH'(bus.in_mask);

  always_comb begin
    in_entry       = '0;
    in_entry.addr  = bus.in_addr;
    in_entry.wdata = bus.in_wdata;
    in_entry.strb  = lane_mask_to_strb(mask_ext, bus.in_addr[4:2]);
  end

  // Stall depends on registered occupancy only, so dram_req_ready never
  // reaches be_stall combinationally; a same-cycle dequeue frees the slot
  // one cycle later.
  assign accept = bus.in_valid && !fifo_full;
  // A beat whose strobe is all zero is consumed from the latch but dropped.
  assign push   = accept && (in_entry.strb != '0);

  assign req_valid = !fifo_empty && (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign issue     = req_valid && bus.dram_req_ready;

  scpad_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_en   (push),
    .wr_data (in_entry),
    .rd_en   (issue),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Increments only on an issue, so once req_valid is up the limit cannot
  // drop it before the handshake.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      outstanding <= '0;
      err_resp    <= 1'b0;
    end else begin
      case ({issue, bus.dram_resp_valid})
        2'b10: outstanding <= outstanding + OUT_W'(1);
        2'b01: begin
          if (outstanding == '0) err_resp <= 1'b1;
          else                   outstanding <= outstanding - OUT_W'(1);
        end
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign bus.be_stall       = fifo_full;
  assign bus.dram_req_valid = req_valid;
  assign bus.dram_req_addr  = head.addr;
  assign bus.dram_req_wdata = head.wdata;
  assign bus.dram_req_strb  = head.strb;
  assign bus.outstanding    = outstanding;
  assign bus.idle           = (fifo_count == '0) && (outstanding == '0);
  assign bus.err_resp       = err_resp;

endmodule

// File: tb/tb_dram_write_buffer.sv
module tb_dram_write_buffer;
  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dram_write_buffer_if #(
    .DRAM_ADDR_WIDTH (32),
    .NUM_COLS        (32),
    .MAX_OUTSTANDING (8)
  ) bus ();

  dram_write_buffer #(
    .DEPTH           (4),
    .DRAM_ADDR_WIDTH (32),
    .NUM_COLS        (32),
    .MAX_OUTSTANDING (8)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake the DUT performs must match the head of exp_q.
  always @(negedge clk) begin
    if (n_rst && bus.dram_req_valid && bus.dram_req_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got addr=%0h data=%0h strb=%0h expected no request",
                 bus.dram_req_addr, bus.dram_req_wdata, bus.dram_req_strb);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.dram_req_addr !== e.addr || bus.dram_req_wdata !== e.data ||
            bus.dram_req_strb !== e.strb) begin
          errors++;
          $display("FAIL issue_beat: got addr=%0h data=%0h strb=%0h expected addr=%0h data=%0h strb=%0h",
                   bus.dram_req_addr, bus.dram_req_wdata, bus.dram_req_strb, e.addr, e.data, e.strb);
        end
      end
    end
  end

  // Presents a beat until accepted; strb is the hand-computed expectation.
  task automatic push_beat(input logic [31:0] a, input logic [31:0] m,
                           input logic [63:0] d, input logic [7:0] s);
    logic stall;
    bit   done;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_mask  = m;
    bus.in_wdata = d;
    for (int i = 0; i < 100 && !done; i++) begin
      stall = bus.be_stall;
      tick();
      if (!stall) begin
        done = 1;
        if (s != 8'h00) exp_q.push_back('{addr: a, data: d, strb: s});
      end
    end
    if (!done) chk("push_timeout", 64'(1), 64'(0));
    bus.in_valid = 1'b0;
  endtask

  task automatic acks(input int n);
    bus.dram_resp_valid = 1'b1;
    repeat (n) tick();
    bus.dram_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bp_strb [5];
    bit ok;
    bp_strb = '{8'h03, 8'hC0, 8'h30, 8'h0C, 8'h03};
    bus.in_valid = 1'b0;
    bus.in_wdata = '0;
    bus.in_addr = '0;
    bus.in_mask = '0;
    bus.dram_req_ready = 1'b0;
    bus.dram_resp_valid = 1'b0;

    // Reset state
    tick();
    chk("rst_be_stall", 64'(bus.be_stall), 64'(0));
    chk("rst_req_valid", 64'(bus.dram_req_valid), 64'(0));
    chk("rst_idle", 64'(bus.idle), 64'(1));
    chk("rst_outstanding", 64'(bus.outstanding), 64'(0));
    chk("rst_err", 64'(bus.err_resp), 64'(0));
    chk("rst_req_data", bus.dram_req_wdata, 64'(0));
    chk("rst_req_strb", 64'(bus.dram_req_strb), 64'(0));
    n_rst = 1'b1;
    tick();

    // Single beat, b=2, lanes 8..11 set -> full strobe
    bus.dram_req_ready = 1'b1;
    push_beat(32'h1000_0008, 32'h0000_0F00, 64'hDDDDCCCCBBBBAAAA, 8'hFF);
    chk("single_valid", 64'(bus.dram_req_valid), 64'(1));
    chk("single_strb", 64'(bus.dram_req_strb), 64'hFF);
    tick();
    chk("single_out1", 64'(bus.outstanding), 64'(1));
    chk("single_not_idle", 64'(bus.idle), 64'(0));
    acks(1);
    chk("single_out0", 64'(bus.outstanding), 64'(0));
    chk("single_idle", 64'(bus.idle), 64'(1));

    // Partial mask (b=0, lanes 0 and 2) and all-zero strobe (b=1)
    push_beat(32'h1000_0000, 32'h0000_0005, 64'h0123_4567_89AB_CDEF, 8'h33);
    tick();
    acks(1);
    push_beat(32'h1000_0004, 32'h0000_000F, 64'hFFFF_0000_FFFF_0000, 8'h00);
    chk("zero_strb_valid", 64'(bus.dram_req_valid), 64'(0));
    chk("zero_strb_stall", 64'(bus.be_stall), 64'(0));
    tick();
    chk("zero_strb_valid2", 64'(bus.dram_req_valid), 64'(0));
    chk("zero_strb_idle", 64'(bus.idle), 64'(1));

    // Back-pressure: 4 beats fill the FIFO, 5th waits for the first dequeue
    bus.dram_req_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      push_beat(32'h2000_0000 + 32'(4*k), 32'h0001_2481, 64'hA5A5_0000_0000_0000 | 64'(k), bp_strb[k]);
    chk("bp_full_stall", 64'(bus.be_stall), 64'(1));
    chk("bp_full_valid", 64'(bus.dram_req_valid), 64'(1));
    fork
      push_beat(32'h2000_0010, 32'h0001_2481, 64'hA5A5_0000_0000_0004, bp_strb[4]);
      begin
        tick();
        tick();
        chk("bp_still_stall", 64'(bus.be_stall), 64'(1));
        bus.dram_req_ready = 1'b1;
        tick();
        chk("bp_stall_release", 64'(bus.be_stall), 64'(0));
      end
    join
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.outstanding == 4'd5 && !bus.dram_req_valid) ok = 1;
      else tick();
    end
    chk("bp_drained_out5", 64'(bus.outstanding), 64'(5));
    acks(5);
    chk("bp_acked", 64'(bus.outstanding), 64'(0));

    // Outstanding throttle: 10 beats, no acks -> 8 issued, 2 held
    for (int k = 0; k < 10; k++)
      push_beat(32'h3000_0000 + 32'(4*k), 32'hFFFF_FFFF, 64'hC0DE_0000_0000_0000 | 64'(k), 8'hFF);
    tick();
    chk("thr_out8", 64'(bus.outstanding), 64'(8));
    chk("thr_valid_blocked", 64'(bus.dram_req_valid), 64'(0));
    chk("thr_no_stall", 64'(bus.be_stall), 64'(0));
    bus.dram_resp_valid = 1'b1;
    tick();
    chk("thr_out7", 64'(bus.outstanding), 64'(7));
    chk("thr_valid_again", 64'(bus.dram_req_valid), 64'(1));
    tick();
    chk("thr_issue_and_ack", 64'(bus.outstanding), 64'(7));
    bus.dram_resp_valid = 1'b0;
    tick();
    chk("thr_last_issue", 64'(bus.outstanding), 64'(8));
    chk("thr_empty_valid", 64'(bus.dram_req_valid), 64'(0));
    acks(8);
    chk("thr_idle", 64'(bus.idle), 64'(1));

    // Spurious ack
    acks(1);
    chk("spur_err", 64'(bus.err_resp), 64'(1));
    chk("spur_out", 64'(bus.outstanding), 64'(0));
    tick();
    chk("spur_sticky", 64'(bus.err_resp), 64'(1));

    // Reset mid-stream: 2 outstanding, 3 queued
    push_beat(32'h4000_0000, 32'hFFFF_FFFF, 64'h4444_0000_0000_0000, 8'hFF);
    push_beat(32'h4000_0004, 32'hFFFF_FFFF, 64'h4444_0000_0000_0001, 8'hFF);
    tick();
    bus.dram_req_ready = 1'b0;
    for (int k = 2; k < 5; k++)
      push_beat(32'h4000_0000 + 32'(4*k), 32'hFFFF_FFFF, 64'h4444_0000_0000_0000 | 64'(k), 8'hFF);
    chk("mid_out2", 64'(bus.outstanding), 64'(2));
    chk("mid_not_idle", 64'(bus.idle), 64'(0));
    n_rst = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_out", 64'(bus.outstanding), 64'(0));
    chk("mid_rst_stall", 64'(bus.be_stall), 64'(0));
    chk("mid_rst_valid", 64'(bus.dram_req_valid), 64'(0));
    chk("mid_rst_idle", 64'(bus.idle), 64'(1));
    chk("mid_rst_err", 64'(bus.err_resp), 64'(0));
    tick();
    n_rst = 1'b1;
    bus.dram_req_ready = 1'b1;
    tick();
    push_beat(32'h5000_000C, 32'h0000_3000, 64'h5555_6666_7777_8888, 8'h0F);
    chk("post_rst_valid", 64'(bus.dram_req_valid), 64'(1));
    tick();
    chk("post_rst_out1", 64'(bus.outstanding), 64'(1));
    acks(1);
    chk("post_rst_idle", 64'(bus.idle), 64'(1));

    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
